// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the 4-digit seven-segment display path.
package seg_disp_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int SEL_W      = 2;
  localparam int NIB_W      = 4;
  localparam int FRAME_W    = 16;

  typedef logic [SEL_W-1:0]      digit_sel_t;
  typedef logic [NUM_DIGITS-1:0] an_t;

  localparam an_t        AN_OFF     = 4'b1111;
  localparam digit_sel_t LAST_DIGIT = digit_sel_t'(NUM_DIGITS - 1);
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-update handshake between the data producer and the scan controller.
interface seg_scan_ctrl_if;
  import seg_disp_pkg::*;

  logic                  upd_req;
  logic [FRAME_W-1:0]    data_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  upd_ack;

  modport master (output upd_req, data_in, dp_in, input upd_ack);
  modport slave  (input upd_req, data_in, dp_in, output upd_ack);
endinterface

// File: rtl/seg_tick_div.sv
// Digit-slot prescaler: counts 0..TICK_DIV-1 while enabled, held at 0 otherwise.
module seg_tick_div #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] div_cnt,
  output logic             tick
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  generate
    if (TICK_DIV < 2) begin : g_bad_div
      $fatal(1, "seg_tick_div: TICK_DIV must be >= 2");
    end
  endgenerate

  assign tick = en && !clr && (div_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!en || clr || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller with frame-aligned update handshake and dead-time blanking.
// Optional digit blinking is enabled by defining SEG_BLINK_EN.
module seg_scan_ctrl
  import seg_disp_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int DEAD_CYC   = 64,
  parameter int BLINK_LOG2 = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  seg_scan_ctrl_if.slave      upd,
  output digit_sel_t          scan_sel,
  output logic [FRAME_W-1:0]  data_cur,
  output an_t                 an,
  output logic                dp,
  output logic                frame_done
`ifdef SEG_BLINK_EN
  ,
  input  logic [NUM_DIGITS-1:0] blink_mask
`endif
);
  localparam int               CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYC);

  generate
    if (DEAD_CYC < 0 || DEAD_CYC >= TICK_DIV) begin : g_bad_dead
      $fatal(1, "seg_scan_ctrl: DEAD_CYC must satisfy 0 <= DEAD_CYC < TICK_DIV");
    end
    if (BLINK_LOG2 < 1) begin : g_bad_blink
      $fatal(1, "seg_scan_ctrl: BLINK_LOG2 must be >= 1");
    end
  endgenerate

  logic [CNT_W-1:0]      div_cnt;
  logic [CNT_W-1:0]      div_next;
  logic                  tick;

  digit_sel_t            sel_reg, sel_next;
  logic [FRAME_W-1:0]    data_reg, data_next;
  logic [NUM_DIGITS-1:0] dp_cur_reg, dp_cur_next;
  an_t                   an_reg, an_next;
  logic                  dp_reg, dp_next;
  logic                  ack_reg, ack_next;
  logic                  frame_done_reg;
  logic                  dark_done_reg, dark_done_next;
  logic                  boundary, dark_load, load, active, blanked;

`ifdef SEG_BLINK_EN
  logic [BLINK_LOG2-1:0] frame_cnt_reg, frame_cnt_next;
`endif

  seg_tick_div #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .clr     (1'b0),
    .div_cnt (div_cnt),
    .tick    (tick)
  );

  always_comb begin
    // Mirror of the prescaler's next count so an/dp line up with the slot they describe.
    div_next = (!en || tick) ? '0 : div_cnt + 1'b1;
    sel_next = !en ? '0 : (tick ? sel_reg + 1'b1 : sel_reg);

    boundary  = tick && (sel_reg == LAST_DIGIT);
    // While dark, load once per request; dark_done stops a held request from re-acking.
    dark_load = !en && upd.upd_req && !ack_reg && !dark_done_reg;
    load      = (boundary && upd.upd_req) || dark_load;

    data_next      = load ? upd.data_in : data_reg;
    dp_cur_next    = load ? upd.dp_in : dp_cur_reg;
    ack_next       = load;
    dark_done_next = en ? 1'b0 : (upd.upd_req && (dark_done_reg || dark_load));

    blanked = 1'b0;
`ifdef SEG_BLINK_EN
    frame_cnt_next = boundary ? frame_cnt_reg + 1'b1 : frame_cnt_reg;
    blanked        = frame_cnt_next[BLINK_LOG2-1] && blink_mask[sel_next];
`endif

    active  = en && (div_next >= DEAD_LIM) && !blanked;
    an_next = active ? ~(an_t'(1) << sel_next) : AN_OFF;
    dp_next = active ? ~dp_cur_next[sel_next] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg        <= '0;
      data_reg       <= '0;
      dp_cur_reg     <= '0;
      an_reg         <= AN_OFF;
      dp_reg         <= 1'b1;
      ack_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
      dark_done_reg  <= 1'b0;
    end else begin
      sel_reg        <= sel_next;
      data_reg       <= data_next;
      dp_cur_reg     <= dp_cur_next;
      an_reg         <= an_next;
      dp_reg         <= dp_next;
      ack_reg        <= ack_next;
      frame_done_reg <= boundary;
      dark_done_reg  <= dark_done_next;
    end
  end

`ifdef SEG_BLINK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= '0;
    end else begin
      frame_cnt_reg <= frame_cnt_next;
    end
  end
`endif

  assign scan_sel    = sel_reg;
  assign data_cur    = data_reg;
  assign an          = an_reg;
  assign dp          = dp_reg;
  assign frame_done  = frame_done_reg;
  assign upd.upd_ack = ack_reg;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (TICK_DIV=8, DEAD_CYC=2, BLINK_LOG2=1); blink test under SEG_BLINK_EN.
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  scan_sel;
  logic [15:0] data_cur;
  logic [3:0]  an;
  logic        dp;
  logic        frame_done;
`ifdef SEG_BLINK_EN
  logic [3:0]  blink_mask;
`endif

  int total = 0;
  int bad   = 0;

  seg_scan_ctrl_if bus();

  seg_scan_ctrl #(
    .TICK_DIV   (8),
    .DEAD_CYC   (2),
    .BLINK_LOG2 (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .upd        (bus),
    .scan_sel   (scan_sel),
    .data_cur   (data_cur),
    .an         (an),
    .dp         (dp),
    .frame_done (frame_done)
`ifdef SEG_BLINK_EN
    ,
    .blink_mask (blink_mask)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        req;
    logic [15:0] din;
    logic [3:0]  dpin;
    logic [1:0]  sel;
    logic [3:0]  an;
    logic        dp;
    logic        ack;
    logic        fd;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " an"}, 32'(an), 32'hF);
    check({tag, " dp"}, 32'(dp), 32'h1);
    check({tag, " scan_sel"}, 32'(scan_sel), 32'h0);
    check({tag, " data_cur"}, 32'(data_cur), 32'h0);
    check({tag, " upd_ack"}, 32'(bus.upd_ack), 32'h0);
    check({tag, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Scan table: sample i follows clock edge i+1 after enabling with div_cnt=0.
    for (int i = 0; i < 64; i++) begin
      int          c;
      int          s;
      logic        act;
      logic [3:0]  onehot;
      c = (i + 1) % 8;
      s = ((i + 1) / 8) % 4;
      act = (c >= 2);
      onehot = 4'b0001 << s;
      vecs[i].en   = 1'b1;
      vecs[i].req  = (i >= 12 && i <= 31);
      vecs[i].din  = 16'h1234;
      vecs[i].dpin = 4'b0100;
      vecs[i].sel  = 2'(s);
      vecs[i].an   = act ? ~onehot : 4'b1111;
      vecs[i].dp   = (act && i >= 31 && s == 2) ? 1'b0 : 1'b1;
      vecs[i].ack  = (i == 31);
      vecs[i].fd   = ((i + 1) % 32 == 0);
      vecs[i].data = (i >= 31) ? 16'h1234 : 16'h0000;
    end

    en = 1'b0;
    bus.upd_req = 1'b0;
    bus.data_in = '0;
    bus.dp_in   = '0;
`ifdef SEG_BLINK_EN
    blink_mask = 4'b0000;
`endif
    rst_n = 1'b1;

    // Reset takes effect with no clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("reset_noclk");
    repeat (2) step();
    rst_n = 1'b1;

    // Scanning, mid-slot request, frame-boundary latch.
    for (int i = 0; i < 64; i++) begin
      en          = vecs[i].en;
      bus.upd_req = vecs[i].req;
      bus.data_in = vecs[i].din;
      bus.dp_in   = vecs[i].dpin;
      step();
      $display("vec %0d sel=%0d an=%b dp=%b ack=%b fd=%b data=%h", i, scan_sel, an, dp,
               bus.upd_ack, frame_done, data_cur);
      check($sformatf("vec%0d scan_sel", i), 32'(scan_sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d an", i), 32'(an), 32'(vecs[i].an));
      check($sformatf("vec%0d dp", i), 32'(dp), 32'(vecs[i].dp));
      check($sformatf("vec%0d upd_ack", i), 32'(bus.upd_ack), 32'(vecs[i].ack));
      check($sformatf("vec%0d frame_done", i), 32'(frame_done), 32'(vecs[i].fd));
      check($sformatf("vec%0d data_cur", i), 32'(data_cur), 32'(vecs[i].data));
    end

    // Loading while dark: one ack, no repeat while req is held.
    en = 1'b0;
    bus.upd_req = 1'b1;
    bus.data_in = 16'hBEEF;
    bus.dp_in   = 4'b0000;
    step();
    $display("dark load: ack=%b data=%h an=%b", bus.upd_ack, data_cur, an);
    check("dark ack", 32'(bus.upd_ack), 32'h1);
    check("dark data_cur", 32'(data_cur), 32'hBEEF);
    check("dark an", 32'(an), 32'hF);
    check("dark scan_sel", 32'(scan_sel), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      $display("dark hold %0d: ack=%b fd=%b an=%b", k, bus.upd_ack, frame_done, an);
      check($sformatf("dark hold%0d ack", k), 32'(bus.upd_ack), 32'h0);
      check($sformatf("dark hold%0d fd", k), 32'(frame_done), 32'h0);
      check($sformatf("dark hold%0d an", k), 32'(an), 32'hF);
      check($sformatf("dark hold%0d data", k), 32'(data_cur), 32'hBEEF);
    end
    bus.upd_req = 1'b0;

    // Async reset in slot 2 with a pending request.
    en = 1'b1;
    begin
      int  n;
      n = 0;
      step();
      while (scan_sel != 2'd2 && n < 40) begin
        step();
        n++;
      end
      check("wait slot2 reached", 32'(n < 40), 32'h1);
    end
    bus.upd_req = 1'b1;
    bus.data_in = 16'h5A5A;
    bus.dp_in   = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-slot: sel=%0d an=%b data=%h", scan_sel, an, data_cur);
    check_reset_vals("reset_mid");
    step();
    check_reset_vals("reset_held");
    bus.upd_req = 1'b0;
    #4 rst_n = 1'b1;
    step();
    $display("post reset 1: sel=%0d an=%b", scan_sel, an);
    check("post1 scan_sel", 32'(scan_sel), 32'h0);
    check("post1 an dead", 32'(an), 32'hF);
    check("post1 ack", 32'(bus.upd_ack), 32'h0);
    step();
    $display("post reset 2: sel=%0d an=%b", scan_sel, an);
    check("post2 scan_sel", 32'(scan_sel), 32'h0);
    check("post2 an", 32'(an), 32'hE);

`ifdef SEG_BLINK_EN
    begin
      int         idx[5];
      logic [3:0] exp_an[5];
      int         p;
      idx[0] = 3;  exp_an[0] = 4'b1110;
      idx[1] = 35; exp_an[1] = 4'b1111;
      idx[2] = 43; exp_an[2] = 4'b1101;
      idx[3] = 59; exp_an[3] = 4'b0111;
      idx[4] = 67; exp_an[4] = 4'b1110;
      en = 1'b0;
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      blink_mask = 4'b0001;
      en = 1'b1;
      p = 0;
      for (int i = 0; i < 68; i++) begin
        step();
        if (p < 5 && i == idx[p]) begin
          $display("blink i=%0d sel=%0d an=%b", i, scan_sel, an);
          check($sformatf("blink i%0d an", i), 32'(an), 32'(exp_an[p]));
          p++;
        end
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
